// File: rtl/password_lock.sv
// Four-digit keypad lock: synchronised push-buttons, digit entry, code check, timed OPEN/FAIL dwell.
// Define LOCKOUT_EN to add a timed LOCKOUT state after MAX_FAILS consecutive failures.
module password_lock #(
    parameter logic [13:0] PASSWORD    = 14'd1234,
    parameter int unsigned HOLD_CYCLES = 50_000_000,
    parameter int unsigned LOCK_CYCLES = 250_000_000,
    parameter int unsigned MAX_FAILS   = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  digit_in,
    input  logic        enter,
    input  logic        clr,
    output logic [13:0] disp_value,
    output logic [2:0]  digit_cnt,
    output logic        unlocked,
    output logic        error,
    output logic        locked_out,
    output logic [1:0]  fails
);

    localparam int unsigned DWELL_MAX = (HOLD_CYCLES > LOCK_CYCLES) ? HOLD_CYCLES : LOCK_CYCLES;
    localparam int unsigned DW        = (DWELL_MAX > 2) ? $clog2(DWELL_MAX) : 1;
    localparam logic [DW-1:0] HOLD_LAST = DW'(HOLD_CYCLES - 1);

    if (MAX_FAILS < 1 || MAX_FAILS > 3) begin : g_max_fails_range
        $error("MAX_FAILS must be in 1..3 to fit the fails counter");
    end

`ifdef LOCKOUT_EN
    localparam logic [DW-1:0] LOCK_LAST  = DW'(LOCK_CYCLES - 1);
    localparam logic [1:0]    FAIL_LIMIT = 2'(MAX_FAILS);

    typedef enum logic [2:0] {ENTRY, CHECK, OPEN, FAIL, LOCKOUT} state_t;
`else
    typedef enum logic [2:0] {ENTRY, CHECK, OPEN, FAIL} state_t;
`endif

    state_t        state;
    logic [DW-1:0] dwell;

    // [0],[1] synchronise; [2] holds the previous synchronised level for edge detection
    logic [2:0]  enter_sync;
    logic [2:0]  clr_sync;
    logic [1:0]  warm;
    logic        enter_armed;
    logic        clr_armed;
    logic        enter_pulse;
    logic        clr_pulse;
    logic [13:0] next_value;

    // A button only arms once it has been seen released after reset, so a press held
    // through reset release never produces an edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            enter_sync  <= '0;
            clr_sync    <= '0;
            warm        <= '0;
            enter_armed <= 1'b0;
            clr_armed   <= 1'b0;
        end else begin
            enter_sync  <= {enter_sync[1:0], enter};
            clr_sync    <= {clr_sync[1:0], clr};
            warm        <= {warm[0], 1'b1};
            enter_armed <= enter_armed | (warm[1] & ~enter_sync[1]);
            clr_armed   <= clr_armed | (warm[1] & ~clr_sync[1]);
        end
    end

    always_comb begin
        enter_pulse = enter_armed & enter_sync[1] & ~enter_sync[2];
        clr_pulse   = clr_armed & clr_sync[1] & ~clr_sync[2];
        next_value  = disp_value * 14'd10 + {10'd0, digit_in};
    end

`ifndef LOCKOUT_EN
    assign locked_out = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ENTRY;
            dwell      <= '0;
            disp_value <= '0;
            digit_cnt  <= '0;
            unlocked   <= 1'b0;
            error      <= 1'b0;
            fails      <= '0;
`ifdef LOCKOUT_EN
            locked_out <= 1'b0;
`endif
        end else begin
            case (state)
                ENTRY: begin
                    dwell <= '0;
                    if (clr_pulse) begin
                        disp_value <= '0;
                        digit_cnt  <= '0;
                    end else if (enter_pulse && digit_in <= 4'd9) begin
                        disp_value <= next_value;
                        digit_cnt  <= digit_cnt + 3'd1;
                        if (digit_cnt == 3'd3) begin
                            state <= CHECK;
                        end
                    end
                end
                CHECK: begin
                    dwell <= '0;
                    if (disp_value == PASSWORD) begin
                        state    <= OPEN;
                        unlocked <= 1'b1;
                        fails    <= '0;
                    end else begin
                        state <= FAIL;
                        error <= 1'b1;
                        if (fails != 2'd3) begin
                            fails <= fails + 2'd1;
                        end
                    end
                end
                OPEN: begin
                    dwell <= dwell + 1'b1;
                    if (dwell == HOLD_LAST) begin
                        state      <= ENTRY;
                        dwell      <= '0;
                        unlocked   <= 1'b0;
                        disp_value <= '0;
                        digit_cnt  <= '0;
                    end
                end
                FAIL: begin
                    dwell <= dwell + 1'b1;
                    if (dwell == HOLD_LAST) begin
                        state      <= ENTRY;
                        dwell      <= '0;
                        error      <= 1'b0;
                        disp_value <= '0;
                        digit_cnt  <= '0;
`ifdef LOCKOUT_EN
                        if (fails == FAIL_LIMIT) begin
                            state      <= LOCKOUT;
                            locked_out <= 1'b1;
                        end
`endif
                    end
                end
`ifdef LOCKOUT_EN
                LOCKOUT: begin
                    dwell <= dwell + 1'b1;
                    if (dwell == LOCK_LAST) begin
                        state      <= ENTRY;
                        dwell      <= '0;
                        locked_out <= 1'b0;
                        fails      <= '0;
                    end
                end
`endif
                default: begin
                    state <= ENTRY;
                    dwell <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_password_lock.sv
// Randomised scoreboard bench for password_lock: a code-level model predicts every change of the
// output tuple, and a monitor compares each observed change, its arrival cycle and its dwell.
module tb_password_lock;

    localparam int unsigned HOLD = 4;
    localparam int unsigned LOCK = 8;
    localparam int          CODE = 1234;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  digit_in = '0;
    logic        enter = 1'b0;
    logic        clr = 1'b0;
    logic [13:0] disp_value;
    logic [2:0]  digit_cnt;
    logic        unlocked;
    logic        error;
    logic        locked_out;
    logic [1:0]  fails;

    password_lock #(
        .PASSWORD   (14'(CODE)),
        .HOLD_CYCLES(HOLD),
        .LOCK_CYCLES(LOCK),
        .MAX_FAILS  (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .digit_in  (digit_in),
        .enter     (enter),
        .clr       (clr),
        .disp_value(disp_value),
        .digit_cnt (digit_cnt),
        .unlocked  (unlocked),
        .error     (error),
        .locked_out(locked_out),
        .fails     (fails)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [21:0] snap;
        int          len;   // expected dwell in cycles, 0 = any
        longint      at;    // expected first-seen cycle, -1 = any
    } exp_t;

    exp_t        exp_q[$];
    int          total = 0;
    int          bad = 0;
    longint      cyc = 0;

    // reference model of the lock at code level
    int          m_disp = 0;
    int          m_cnt = 0;
    int          m_fails = 0;
    bit          m_lock = 0;
    logic [21:0] m_last = '0;

    always @(posedge clk) cyc++;

    function automatic logic [21:0] cur_snap();
        return {disp_value, digit_cnt, unlocked, error, locked_out, fails};
    endfunction

    task automatic check(input string name, input longint act, input longint req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push(input int d, input int c, input bit u, input bit e, input bit l,
                        input int f, input int len, input longint at);
        exp_t x;
        x.snap = {14'(d), 3'(c), u, e, l, 2'(f)};
        x.len  = len;
        x.at   = at;
        if (x.snap != m_last) begin
            exp_q.push_back(x);
            m_last = x.snap;
        end
    endtask

    // monitor: every change of the output tuple consumes one expected entry
    logic        mon_en = 1'b0;
    logic [21:0] prev_snap = '0;
    int          run_len = 0;
    exp_t        pend;
    bit          have_pend = 0;

    always @(negedge clk) begin : monitor
        logic [21:0] cur;
        exp_t        e;
        if (mon_en) begin
            cur = cur_snap();
            if (cur != prev_snap) begin
                if (have_pend && pend.len != 0) check("dwell", run_len, pend.len);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_change: got 0x%0h required 0x%0h unchanged (cycle %0d)",
                             cur, prev_snap, cyc);
                    have_pend = 0;
                end else begin
                    e = exp_q.pop_front();
                    check("outputs", cur, e.snap);
                    if (e.at >= 0) check("latency", cyc, e.at);
                    pend = e;
                    have_pend = 1;
                end
                prev_snap = cur;
                run_len = 1;
            end else begin
                run_len++;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_until(input longint t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic resolve(input longint c);
        if (m_disp == CODE) begin
            m_fails = 0;
            m_lock  = 0;
            push(m_disp, 4, 1, 0, 0, 0, HOLD, c + 4);
            push(0, 0, 0, 0, 0, 0, 0, c + 4 + HOLD);
        end else begin
            if (m_fails < 3) m_fails++;
            push(m_disp, 4, 0, 1, 0, m_fails, HOLD, c + 4);
            m_lock = 0;
`ifdef LOCKOUT_EN
            if (m_fails == 3) m_lock = 1;
`endif
            if (m_lock) begin
                push(0, 0, 0, 0, 1, m_fails, LOCK, c + 4 + HOLD);
                m_fails = 0;
                push(0, 0, 0, 0, 0, 0, 0, c + 4 + HOLD + LOCK);
            end else begin
                push(0, 0, 0, 0, 0, m_fails, 0, c + 4 + HOLD);
            end
        end
    endtask

    // presses while the lock is busy must all be discarded
    task automatic busy(input longint c);
        tick(1); enter = 1'b0; clr = 1'b1;
        tick(1); clr = 1'b0;
        tick(1); enter = 1'b1; digit_in = 4'($urandom_range(0, 9));
        tick(1); enter = 1'b0;
        if (m_lock) begin
            wait_until(c + 10);
            enter = 1'b1; clr = 1'b1;
            tick(2);
            enter = 1'b0; clr = 1'b0;
        end
        wait_until(c + 4 + HOLD + (m_lock ? LOCK : 0) + 4);
        m_disp = 0;
        m_cnt  = 0;
    endtask

    task automatic do_enter(input int d, input int h);
        longint c;
        bit     done;
        c = cyc;
        done = 0;
        digit_in = 4'(d);
        enter = 1'b1;
        if (d <= 9) begin
            m_disp = m_disp * 10 + d;
            m_cnt++;
            push(m_disp, m_cnt, 0, 0, 0, m_fails, (m_cnt == 4) ? 1 : 0, c + 3);
            if (m_cnt == 4) begin
                resolve(c);
                done = 1;
            end
        end
        if (done) begin
            busy(c);
        end else begin
            tick(h);
            enter = 1'b0;
            tick(2);
        end
    endtask

    task automatic do_clr(input int h, input bit with_enter, input int d);
        longint c;
        c = cyc;
        clr = 1'b1;
        if (with_enter) begin
            digit_in = 4'(d);
            enter = 1'b1;
        end
        m_disp = 0;
        m_cnt  = 0;
        push(0, 0, 0, 0, 0, m_fails, 0, c + 3);
        tick(h);
        clr = 1'b0;
        enter = 1'b0;
        tick(2);
    endtask

    task automatic do_code(input int a, input int b, input int c, input int d);
        do_enter(a, $urandom_range(1, 4));
        do_enter(b, $urandom_range(1, 4));
        do_enter(c, $urandom_range(1, 4));
        do_enter(d, $urandom_range(1, 4));
    endtask

    initial begin
        #2 rst = 1'b0;
        @(negedge clk);
        check("reset", cur_snap(), 0);
        prev_snap = '0;
        mon_en = 1'b1;
        rst = 1'b1;
        tick(4);

        do_enter(1, 2); do_enter(2, 1); do_enter(3, 3); do_enter(4, 1);
        do_enter(1, 1); do_enter(2, 4); do_enter(3, 2); do_enter(5, 1);
        do_enter(7, 2); do_enter(12, 2); do_enter(3, 1);
        do_clr(2, 0, 0);
        do_enter(5, 1); do_enter(6, 3);
        do_clr(2, 1, 8);
        do_code(9, 9, 9, 9);
        do_code(0, 0, 0, 1);
        do_code(4, 3, 2, 1);
        do_code(1, 2, 3, 4);

        // reset mid-entry with enter held through release
        do_enter(2, 1); do_enter(7, 2);
        digit_in = 4'd9;
        enter = 1'b1;
        tick(1);
        m_disp = 0; m_cnt = 0; m_fails = 0;
        push(0, 0, 0, 0, 0, 0, 0, -1);
        #2 rst = 1'b0;
        #1 check("reset_async", cur_snap(), 0);
        tick(2);
        rst = 1'b1;
        tick(6);
        enter = 1'b0;
        tick(3);
        do_enter(5, 2);
        do_clr(1, 0, 0);

        for (int i = 0; i < 60; i++) begin
            int r;
            r = $urandom_range(0, 11);
            if (m_cnt == 0 && r == 0) do_code(1, 2, 3, 4);
            else if (r == 1) do_clr($urandom_range(1, 4), 0, 0);
            else if (r == 2) do_clr($urandom_range(1, 4), 1, $urandom_range(0, 15));
            else if (r == 3) do_enter($urandom_range(10, 15), $urandom_range(1, 4));
            else do_enter($urandom_range(0, 9), $urandom_range(1, 4));
        end

        tick(10);
        check("drain", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
